receiver_buffer: RTL
====================

# receiver_buffer

Parametrised successor to the receiver's 16x16 storage block. It adds configurable width and depth, a registered read with a valid strobe, and a run-time FIFO mode with full/empty tracking and sticky error flags. It sits between the receiver deframer (writer) and the downstream consumer (reader). In random-access mode it behaves as an addressed RAM; in FIFO mode it behaves as a ring buffer.

## Interface
- DATA_WIDTH, 16, word width in bits
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- Mode  in  1  0 = random access, 1 = FIFO
- DataIn  in  DATA_WIDTH  write data
- Address  in  ADDR_WIDTH  word address; ignored in FIFO mode
- WriteEnable  in  1  write request
- ReadEnable  in  1  read request
- DataOut  out  DATA_WIDTH  registered read data
- DataValid  out  1  one-cycle strobe; DataOut was updated this cycle
- Full  out  1  FIFO holds 2**ADDR_WIDTH words
- Empty  out  1  FIFO holds 0 words
- Count  out  ADDR_WIDTH+1  FIFO occupancy
- Overflow  out  1  sticky; a FIFO write was dropped
- Underflow  out  1  sticky; a FIFO read was dropped

## Operation
- Reset is sampled at the clk edge while rst_n=0. After reset:
  - DataOut=0, DataValid=0.
  - Write/read pointers=0, Count=0, Empty=1, Full=0.
  - Overflow=0, Underflow=0.
  - Memory contents are not cleared.
- Random mode (Mode=0):
  - WriteEnable=1: mem[Address] <= DataIn.
  - ReadEnable=1: DataOut <= mem[Address] and DataValid=1 on the next cycle.
  - DataOut holds its value between reads.
  - Addresses wrap naturally; the caller's Address+1 from 2**ADDR_WIDTH-1 becomes 0.
  - Same-address simultaneous read and write: see Configuration.
- FIFO mode (Mode=1):
  - A write is accepted if !Full, or if Full and a read is accepted in the same cycle.
  - An accepted write stores mem[wptr] and increments wptr modulo depth.
  - A read is accepted if !Empty. It sets DataOut <= mem[rptr] and increments rptr modulo depth.
  - An accepted read raises DataValid=1 on the next cycle.
  - Count: +1 on write only, -1 on read only, unchanged on both.
  - Full = (Count == 2**ADDR_WIDTH); Empty = (Count == 0).
  - A write on Full with no accepted read is dropped and sets Overflow.
  - A read on Empty is dropped and sets Underflow; DataValid stays 0 and DataOut is held.
  - Simultaneous read and write on Empty: only the write is accepted and Underflow is set. Data is never forwarded in FIFO mode.
- Mode change: a registered copy of Mode is kept. In any cycle where Mode differs from that registered copy:
  - Pointers and Count clear to 0.
  - Reads and writes in that cycle are ignored.
  - Overflow, Underflow and memory contents are kept.
- Overflow and Underflow clear only on reset.

## Timing
- Write-to-memory latency: 1 cycle. Data written at edge N is readable from a request sampled at edge N+1 or later.
- Read latency: 1 cycle. A request sampled at edge N gives DataOut/DataValid valid after edge N.
- Status outputs are registered. Count, Full, Empty, Overflow and Underflow all reflect the accepted operations of the previous edge.
- Reset asserted mid-operation overrides everything: any in-flight read produces no DataValid.

## Configuration
- Macro: RECEIVER_BUFFER_BYPASS_EN. It applies in random mode, when ReadEnable=1, WriteEnable=1 and the address is the same.
- Defined: DataOut <= DataIn (write-first).
- Undefined: DataOut <= previous mem[Address] (read-first).
- In both cases the write completes.

## Structure
- Package receiver_pkg holds:
  - MODE_RANDOM=1'b0 and MODE_FIFO=1'b1
  - default DATA_WIDTH and ADDR_WIDTH constants
- Sub-module receiver_ram: a single-clock storage array with one write port and one synchronous read port. Keep it free of reset so it maps to block RAM.
- Pointer, count, flag and mode-change logic live in receiver_buffer.

## Test plan
- Random write/read: write 16'hABCD to address 15, then read 15 the next cycle. Expect DataOut=ABCD and DataValid=1 for exactly one cycle.
- Address wrap:
  - Write DataOut+1 = 16'hABCE to address 15+1 = 0.
  - Read 0 → ABCE.
  - Read 15 → ABCD (unchanged).
- Same-cycle collision: address 3 holds 1111. Read 3 and write 2222 to address 3 in the same cycle. Expect DataOut=2222 with RECEIVER_BUFFER_BYPASS_EN, 1111 without.
- FIFO fill/drain:
  - Write 0..15: Full=1, Count=16.
  - 17th write: dropped, Overflow=1.
  - 16 reads return 0..15 in order, then Empty=1.
  - Extra read: Underflow=1, DataValid=0.
- Full with simultaneous read/write: write 16'h00AA while reading. Count stays 16, Overflow unchanged, and the oldest word is returned.
- Reset and mode switch:
  - Mid-fill at Count=5, toggle Mode: Count=0, Empty=1.
  - Assert rst_n=0 during a read: DataValid=0 next cycle, Overflow/Underflow cleared, DataOut=0.

Source files
------------

// File: rtl/receiver_pkg.sv
// receiver_pkg: mode encodings and default geometry shared by the receiver buffer files.
`default_nettype none

package receiver_pkg;

  localparam logic MODE_RANDOM   = 1'b0;
  localparam logic MODE_FIFO     = 1'b1;

  localparam int   RB_DATA_WIDTH = 16;
  localparam int   RB_ADDR_WIDTH = 4;

endpackage

`default_nettype wire

// File: rtl/receiver_ram.sv
// receiver_ram: single-clock storage array, one write port and one registered read port.
`default_nettype none

module receiver_ram
  import receiver_pkg::*;
#(
  parameter int DATA_WIDTH = RB_DATA_WIDTH,
  parameter int ADDR_WIDTH = RB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // No reset so the array maps onto block RAM; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/receiver_buffer.sv
// receiver_buffer: addressed RAM or ring-buffer FIFO with registered read and sticky error flags.
// Optional macro RECEIVER_BUFFER_BYPASS_EN selects write-first on a random-mode same-address collision.
`default_nettype none

module receiver_buffer
  import receiver_pkg::*;
#(
  parameter int DATA_WIDTH = RB_DATA_WIDTH,
  parameter int ADDR_WIDTH = RB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Mode,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  WriteEnable,
  input  logic                  ReadEnable,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  output logic                  Full,
  output logic                  Empty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam logic [ADDR_WIDTH:0] C_FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, empty_q, ovf_q, unf_q;
  logic                  valid_q, have_data_q;
  logic                  rd_ok, wr_ok, ovf_set, unf_set, mode_chg, fifo;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    mode_chg = (Mode != mode_q);
    fifo     = (Mode == MODE_FIFO);
    rd_ok    = 1'b0;
    wr_ok    = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (!mode_chg) begin
      if (fifo) begin
        // A read on a full FIFO frees a slot for a write in the same cycle.
        rd_ok   = ReadEnable && !empty_q;
        wr_ok   = WriteEnable && (!full_q || rd_ok);
        ovf_set = WriteEnable && !wr_ok;
        unf_set = ReadEnable && empty_q;
      end else begin
        rd_ok = ReadEnable;
        wr_ok = WriteEnable;
      end
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (mode_chg) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else if (fifo) begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  assign waddr = fifo ? wptr_q : Address;
  assign raddr = fifo ? rptr_q : Address;

  receiver_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_ok && rst_n),
    .waddr_i (waddr),
    .wdata_i (DataIn),
    .re_i    (rd_ok && rst_n),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= Mode;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      valid_q     <= 1'b0;
      have_data_q <= 1'b0;
    end else begin
      mode_q  <= Mode;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= (count_d == C_FULL_COUNT);
      empty_q <= (count_d == '0);
      ovf_q   <= ovf_q | ovf_set;
      unf_q   <= unf_q | unf_set;
      valid_q <= rd_ok;
      if (rd_ok) have_data_q <= 1'b1;
    end
  end

`ifdef RECEIVER_BUFFER_BYPASS_EN
  logic                  sel_byp_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_byp_q  <= 1'b0;
      byp_data_q <= '0;
    end else if (rd_ok) begin
      sel_byp_q  <= !fifo && WriteEnable && (raddr == waddr);
      byp_data_q <= DataIn;
    end
  end

  assign DataOut = !have_data_q ? '0 : (sel_byp_q ? byp_data_q : ram_rdata);
`else
  // The RAM output register is unreset, so mask it until the first read lands.
  assign DataOut = have_data_q ? ram_rdata : '0;
`endif

  assign DataValid = valid_q;
  assign Full      = full_q;
  assign Empty     = empty_q;
  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

`default_nettype wire
